// File: rtl/thread_ctrl_axi_slave_pkg.sv
// thread_ctrl_axi_slave_pkg: register offsets, AXI response codes, FSM states and byte-lane merge helper
package thread_ctrl_axi_slave_pkg;
  localparam logic [11:0] OFF_RESUME  = 12'h000;
  localparam logic [11:0] OFF_SUSPEND = 12'h004;
  localparam logic [11:0] OFF_STATUS  = 12'h008;
  localparam logic [11:0] OFF_SCRATCH = 12'h00C;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? data[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/thread_ctrl_axi_slave.sv
// thread_ctrl_axi_slave: AXI4-Lite register window issuing thread resume/suspend pulses
//   clk, reset_n             : clock, async active-low reset
//   s_io_axi_aw*/w*/b*       : write address/data/response channels
//   s_io_axi_ar*/r*          : read address/data channels
//   thread_en                : thread-enable mask, readable through STATUS
//   thread_resume_mask/suspend_mask : one-cycle request pulses, aligned with bvalid rising
module thread_ctrl_axi_slave
  import thread_ctrl_axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h00005000,
  parameter int NUM_THREADS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  s_io_axi_awaddr,
  input  logic [2:0]             s_io_axi_awprot,
  input  logic                   s_io_axi_awvalid,
  output logic                   s_io_axi_awready,
  input  logic [31:0]            s_io_axi_wdata,
  input  logic [3:0]             s_io_axi_wstrb,
  input  logic                   s_io_axi_wvalid,
  output logic                   s_io_axi_wready,
  output logic [1:0]             s_io_axi_bresp,
  output logic                   s_io_axi_bvalid,
  input  logic                   s_io_axi_bready,
  input  logic [ADDR_WIDTH-1:0]  s_io_axi_araddr,
  input  logic [2:0]             s_io_axi_arprot,
  input  logic                   s_io_axi_arvalid,
  output logic                   s_io_axi_arready,
  output logic [31:0]            s_io_axi_rdata,
  output logic [1:0]             s_io_axi_rresp,
  output logic                   s_io_axi_rvalid,
  input  logic                   s_io_axi_rready,
  input  logic [NUM_THREADS-1:0] thread_en,
  output logic [NUM_THREADS-1:0] thread_resume_mask,
  output logic [NUM_THREADS-1:0] thread_suspend_mask
);
  w_state_t r_wstate;
  r_state_t r_rstate;
  logic r_awready, r_wready, r_aw_got, r_w_got, r_bvalid, r_arready, r_rvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0] r_wdata, r_scratch, r_rdata;
  logic [3:0] r_wstrb;
  logic [1:0] r_bresp, r_rresp;
  logic [NUM_THREADS-1:0] r_resume, r_suspend;
  logic w_wmap, w_wok, w_aw_hs, w_w_hs, w_rmap, w_unused;
  logic [11:0] w_woff, w_roff;
  logic [31:0] w_rdata;
  logic [1:0] w_rresp;
  assign w_unused = ^{s_io_axi_awprot, s_io_axi_arprot};
  assign w_aw_hs = s_io_axi_awvalid & r_awready;
  assign w_w_hs  = s_io_axi_wvalid & r_wready;
  assign w_woff  = r_awaddr[11:0];
  assign w_roff  = s_io_axi_araddr[11:0];
  always_comb begin
    w_wmap  = r_awaddr[ADDR_WIDTH-1:12] == BASE_ADDR[ADDR_WIDTH-1:12];
    w_wok   = w_wmap && (w_woff == OFF_RESUME || w_woff == OFF_SUSPEND || w_woff == OFF_SCRATCH);
    w_rmap  = s_io_axi_araddr[ADDR_WIDTH-1:12] == BASE_ADDR[ADDR_WIDTH-1:12];
    w_rdata = !w_rmap ? 32'd0 : w_roff == OFF_STATUS ? 32'(thread_en) : w_roff == OFF_SCRATCH ? r_scratch : 32'd0;
    w_rresp = (w_rmap && (w_roff == OFF_STATUS || w_roff == OFF_SCRATCH)) ? RESP_OKAY : RESP_SLVERR;
  end
  // Ready flags are registered so no AXI input reaches an AXI output combinationally;
  // they stay low through reset and rise on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_resume  <= '0;
      r_suspend <= '0;
      r_scratch <= '0;
    end else begin
      r_resume  <= '0;
      r_suspend <= '0;
      if (r_wstate == W_IDLE) begin
        if (r_aw_got && r_w_got) begin
          r_wstate <= W_RESP;
          r_bvalid <= 1'b1;
          r_bresp  <= w_wok ? RESP_OKAY : RESP_SLVERR;
          if (w_wmap && w_woff == OFF_RESUME) r_resume <= r_wdata[NUM_THREADS-1:0];
          if (w_wmap && w_woff == OFF_SUSPEND) r_suspend <= r_wdata[NUM_THREADS-1:0];
          if (w_wmap && w_woff == OFF_SCRATCH) r_scratch <= strb_merge(r_scratch, r_wdata, r_wstrb);
        end else begin
          if (w_aw_hs) begin
            r_awaddr <= s_io_axi_awaddr;
            r_aw_got <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata <= s_io_axi_wdata;
            r_wstrb <= s_io_axi_wstrb;
            r_w_got <= 1'b1;
          end
          r_awready <= !(r_aw_got || w_aw_hs);
          r_wready  <= !(r_w_got || w_w_hs);
        end
      end else if (s_io_axi_bready) begin
        r_wstate  <= W_IDLE;
        r_bvalid  <= 1'b0;
        r_aw_got  <= 1'b0;
        r_w_got   <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      if (s_io_axi_arvalid && r_arready) begin
        r_rstate  <= R_DATA;
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rdata;
        r_rresp   <= w_rresp;
      end else r_arready <= 1'b1;
    end else if (s_io_axi_rready) begin
      r_rstate  <= R_IDLE;
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end
  assign s_io_axi_awready    = r_awready;
  assign s_io_axi_wready     = r_wready;
  assign s_io_axi_bvalid     = r_bvalid;
  assign s_io_axi_bresp      = r_bresp;
  assign s_io_axi_arready    = r_arready;
  assign s_io_axi_rvalid     = r_rvalid;
  assign s_io_axi_rdata      = r_rdata;
  assign s_io_axi_rresp      = r_rresp;
  assign thread_resume_mask  = r_resume;
  assign thread_suspend_mask = r_suspend;
endmodule

// File: tb/tb_thread_ctrl_axi_slave.sv
// tb_thread_ctrl_axi_slave: directed AXI-Lite transactions checked against a register-map model
module tb_thread_ctrl_axi_slave;
  logic clk, reset_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [3:0] wstrb, thread_en, res, sus;
  logic [1:0] bresp, rresp;
  typedef struct {logic [1:0] resp; logic [3:0] res; logic [3:0] sus;} bexp_t;
  typedef struct {logic [31:0] data; logic [1:0] resp;} rexp_t;
  bexp_t bq[$];
  rexp_t rq[$];
  logic [31:0] m_scratch, d;
  logic [3:0] last_res, last_sus;
  logic prev_bv;
  int n_cmp, n_bad, res_cycles, sus_cycles, b_rises, r0, s0, b0;

  thread_ctrl_axi_slave dut (
    .clk(clk), .reset_n(reset_n),
    .s_io_axi_awaddr(awaddr), .s_io_axi_awprot(awprot), .s_io_axi_awvalid(awvalid), .s_io_axi_awready(awready),
    .s_io_axi_wdata(wdata), .s_io_axi_wstrb(wstrb), .s_io_axi_wvalid(wvalid), .s_io_axi_wready(wready),
    .s_io_axi_bresp(bresp), .s_io_axi_bvalid(bvalid), .s_io_axi_bready(bready),
    .s_io_axi_araddr(araddr), .s_io_axi_arprot(arprot), .s_io_axi_arvalid(arvalid), .s_io_axi_arready(arready),
    .s_io_axi_rdata(rdata), .s_io_axi_rresp(rresp), .s_io_axi_rvalid(rvalid), .s_io_axi_rready(rready),
    .thread_en(thread_en), .thread_resume_mask(res), .thread_suspend_mask(sus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_bad++;
    $display("FAIL %s: handshake never completed", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic bexp_t model_write(input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s);
    bexp_t e;
    e.resp = 2'b10;
    e.res = 4'h0;
    e.sus = 4'h0;
    if (a[31:12] == 20'h00005) begin
      if (a[11:0] == 12'h000) begin e.res = dt[3:0]; e.resp = 2'b00; end
      else if (a[11:0] == 12'h004) begin e.sus = dt[3:0]; e.resp = 2'b00; end
      else if (a[11:0] == 12'h00C) begin
        for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i+:8] = dt[8*i+:8];
        e.resp = 2'b00;
      end
    end
    return e;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] a);
    rexp_t e;
    e.data = 32'h0;
    e.resp = 2'b10;
    if (a[31:12] == 20'h00005 && a[11:0] == 12'h008) begin e.data = {28'h0, thread_en}; e.resp = 2'b00; end
    if (a[31:12] == 20'h00005 && a[11:0] == 12'h00C) begin e.data = m_scratch; e.resp = 2'b00; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_ready", {awready, wready, arready}, 0);
      chk("rst_valid", {bvalid, rvalid}, 0);
      chk("rst_resp", {bresp, rresp}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mask", {res, sus}, 0);
      prev_bv = 1'b0;
    end else begin
      if (bvalid && bq.size() == 0) chk("b_unexpected", bvalid, 0);
      else if (bvalid) begin
        chk("bresp", bresp, bq[0].resp);
        if (!prev_bv) begin
          b_rises++;
          chk("resume_pulse", res, bq[0].res);
          chk("suspend_pulse", sus, bq[0].sus);
        end else chk("mask_hold", {res, sus}, 0);
        if (bready) void'(bq.pop_front());
      end else chk("mask_idle", {res, sus}, 0);
      if (rvalid && rq.size() == 0) chk("r_unexpected", rvalid, 0);
      else if (rvalid) begin
        chk("rdata", rdata, rq[0].data);
        chk("rresp", rresp, rq[0].resp);
        if (rready) void'(rq.pop_front());
      end
      if (res != 0) begin res_cycles++; last_res = res; end
      if (sus != 0) begin sus_cycles++; last_sus = sus; end
      prev_bv = bvalid;
    end
  end

  task automatic do_aw(input logic [31:0] a, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a;
    awvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) timeout("aw_timeout");
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] dt, input logic [3:0] s, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = dt;
    wstrb = s;
    wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wready && n < 50);
    if (!wready) timeout("w_timeout");
    @(posedge clk); #1 wvalid = 0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    int n;
    bq.push_back(model_write(a, dt, s));
    fork
      do_aw(a, aw_dly);
      do_w(dt, s, w_dly);
    join
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    if (!bvalid) timeout("b_timeout");
    chk("b_latency", n, 2);
    for (int i = 1; i < b_dly; i++) begin @(negedge clk); chk("b_hold", bvalid, 1); end
    @(posedge clk); #1 bready = 1;
    @(negedge clk);
    @(posedge clk); #1 bready = 0;
    @(negedge clk); chk("b_done", bvalid, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] dt);
    int n;
    rq.push_back(model_read(a));
    araddr = a;
    arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) timeout("ar_timeout");
    @(posedge clk); #1 arvalid = 0;
    @(negedge clk); chk("r_latency", rvalid, 1);
    dt = rdata;
    @(posedge clk); #1 rready = 1;
    @(negedge clk);
    @(posedge clk); #1 rready = 0;
    @(negedge clk); chk("r_done", rvalid, 0);
    @(posedge clk); #1;
  endtask

  task automatic release_rst();
    reset_n = 1;
    @(negedge clk); chk("ready_before_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    @(negedge clk); chk("ready_after_edge", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
  endtask

  task automatic enter_rst();
    reset_n = 0;
    bq.delete();
    rq.delete();
    m_scratch = 0;
    awvalid = 0;
    wvalid = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; res_cycles = 0; sus_cycles = 0; b_rises = 0;
    m_scratch = 0; last_res = 0; last_sus = 0; prev_bv = 0;
    awaddr = 0; wdata = 0; araddr = 0; awprot = 3'b111; arprot = 3'b101; wstrb = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; thread_en = 0;
    reset_n = 1;
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1 release_rst();
    r0 = res_cycles;
    axi_write(32'h5000, 32'h5, 4'hF, 0, 0, 1);
    chk("lit_resume_0101", last_res, 4'b0101);
    chk("lit_resume_one_cycle", res_cycles - r0, 1);
    s0 = sus_cycles; b0 = b_rises;
    axi_write(32'h5004, 32'h2, 4'hF, 3, 0, 5);
    chk("lit_suspend_0010", last_sus, 4'b0010);
    chk("lit_suspend_one_cycle", sus_cycles - s0, 1);
    chk("lit_single_response", b_rises - b0, 1);
    axi_write(32'h500C, 32'hAABBCCDD, 4'hF, 0, 1, 1);
    axi_write(32'h500C, 32'h11223344, 4'b0101, 1, 0, 2);
    do_read(32'h500C, d);
    chk("lit_scratch_strobe", d, 32'hAA22CC44);
    thread_en = 4'b1001;
    do_read(32'h5008, d);
    chk("lit_status", d, 32'h9);
    r0 = res_cycles; s0 = sus_cycles;
    axi_write(32'h5010, 32'hF, 4'hF, 0, 0, 1);
    do_read(32'h6000, d);
    chk("lit_unmapped_rdata", d, 0);
    axi_write(32'h5008, 32'hFFFF, 4'hF, 0, 0, 1);
    axi_write(32'h1500C, 32'h0, 4'hF, 2, 1, 1);
    axi_write(32'h6000, 32'hF, 4'hF, 0, 0, 1);
    chk("lit_no_pulse", (res_cycles - r0) + (sus_cycles - s0), 0);
    do_read(32'h5000, d);
    do_read(32'h5004, d);
    do_read(32'h500C, d);
    chk("lit_scratch_untouched", d, 32'hAA22CC44);
    axi_write(32'h5000, 32'hA, 4'h0, 1, 1, 1);
    chk("lit_resume_strobe_ignored", last_res, 4'hA);
    bq.push_back(model_write(32'h500C, 32'h12345678, 4'hF));
    fork
      do_aw(32'h500C, 0);
      do_w(32'h12345678, 4'hF, 0);
    join
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!bvalid && n < 50);
      if (!bvalid) timeout("b_before_reset");
    end
    #2 reset_n = 0;
    #1 chk("reset_drops_bvalid", bvalid, 0);
    enter_rst();
    release_rst();
    do_read(32'h500C, d);
    chk("lit_scratch_cleared", d, 0);
    r0 = res_cycles; b0 = b_rises;
    do_aw(32'h5000, 0);
    @(negedge clk);
    chk("aw_only_awready", awready, 0);
    chk("aw_only_wready", wready, 1);
    @(posedge clk); #1;
    enter_rst();
    release_rst();
    repeat (5) @(posedge clk);
    #1;
    chk("lit_no_stale_pulse", res_cycles - r0, 0);
    chk("lit_no_stale_resp", b_rises - b0, 0);
    axi_write(32'h500C, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    do_read(32'h500C, d);
    chk("lit_write_after_reset", d, 32'hCAFEF00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
